// File: rtl/mat_vec_pkg.sv
// Shared types and sizing for the matrix-vector loader slice.
package mat_vec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        UNPK,
        FILL_WAIT,
        DONE
    } state_t;

    localparam int unsigned N_ROWS         = 8;
    localparam int unsigned WORDS_PER_LOAD = 9;
    localparam int unsigned BYTES_PER_WORD = 8;

endpackage

// File: rtl/mat_vec_loader_word_unpacker.sv
// Holds one fetched 64-bit memory word and walks through its bytes, element 0 first.
module word_unpacker
    import mat_vec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] word_in,
    input  logic        active,
    input  logic        stall,
    output logic [7:0]  byte_out,
    output logic        last
);

    logic [63:0] word_q;
    logic [2:0]  b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            b_q    <= '0;
        end else if (load) begin
            word_q <= word_in;
            b_q    <= '0;
        end else if (active && !stall) begin
            b_q <= b_q + 3'd1;
        end
    end

    always_comb begin
        byte_out = word_q[{b_q, 3'b000} +: 8];
        last     = (b_q == 3'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/mat_vec_loader.sv
// Fetches 8 rows of A plus vector B over a pipelined read port and fills the MAC array FIFOs.
module mat_vec_loader
    import mat_vec_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned N      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [63:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic              mem_waitrequest,
    output logic [7:0]        fifo_a_data,
    output logic [N-1:0]      fifo_a_wren,
    input  logic [N-1:0]      fifo_a_full,
    output logic [7:0]        fifo_b_data,
    output logic              fifo_b_wren,
    input  logic              fifo_b_full,
    input  logic              all_fifos_full,
    output logic              clr_accum,
    output logic              start_compute
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        w_q, w_d;

    logic              busy_d, done_d, mem_read_d, clr_d, sc_d, fifo_b_wren_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [7:0]        fifo_a_data_d, fifo_b_data_d;
    logic [N-1:0]      fifo_a_wren_d;

    logic              wu_load, wu_active, wu_last, is_a_row, target_full;
    logic [7:0]        wu_byte;

    word_unpacker u_unpacker (
        .clk      (clk),
        .rst      (rst),
        .load     (wu_load),
        .word_in  (mem_readdata),
        .active   (wu_active),
        .stall    (target_full),
        .byte_out (wu_byte),
        .last     (wu_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_q        <= '0;
            w_q           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_read      <= 1'b0;
            mem_address   <= '0;
            fifo_a_data   <= '0;
            fifo_a_wren   <= '0;
            fifo_b_data   <= '0;
            fifo_b_wren   <= 1'b0;
            clr_accum     <= 1'b0;
            start_compute <= 1'b0;
        end else begin
            state         <= state_d;
            base_q        <= base_d;
            w_q           <= w_d;
            busy          <= busy_d;
            done          <= done_d;
            mem_read      <= mem_read_d;
            mem_address   <= mem_address_d;
            fifo_a_data   <= fifo_a_data_d;
            fifo_a_wren   <= fifo_a_wren_d;
            fifo_b_data   <= fifo_b_data_d;
            fifo_b_wren   <= fifo_b_wren_d;
            clr_accum     <= clr_d;
            start_compute <= sc_d;
        end
    end

    always_comb begin
        state_d       = state;
        base_d        = base_q;
        w_d           = w_q;
        busy_d        = busy;
        done_d        = done;
        mem_read_d    = 1'b0;
        mem_address_d = mem_address;
        fifo_a_data_d = fifo_a_data;
        fifo_a_wren_d = '0;
        fifo_b_data_d = fifo_b_data;
        fifo_b_wren_d = 1'b0;
        clr_d         = 1'b0;
        sc_d          = 1'b0;
        wu_load       = 1'b0;
        wu_active     = 1'b0;
        is_a_row      = (w_q < 4'(N_ROWS));
        target_full   = is_a_row ? fifo_a_full[w_q[2:0]] : fifo_b_full;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    base_d  = base_addr;
                    w_d     = '0;
                    clr_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = REQ;
                end
            end
            // First REQ cycle leaves mem_read low so the previous word's final
            // registered write enable never overlaps a read request.
            REQ: begin
                if (!mem_read) begin
                    mem_read_d    = 1'b1;
                    mem_address_d = base_q + ADDR_W'({w_q, 3'b000});
                end else if (mem_waitrequest) begin
                    mem_read_d = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_readdatavalid) begin
                    wu_load = 1'b1;
                    state_d = UNPK;
                end
            end
            UNPK: begin
                wu_active = 1'b1;
                if (!target_full) begin
                    if (is_a_row) begin
                        fifo_a_wren_d = N'(1) << w_q[2:0];
                        fifo_a_data_d = wu_byte;
                    end else begin
                        fifo_b_wren_d = 1'b1;
                        fifo_b_data_d = wu_byte;
                    end
                    if (wu_last) begin
                        if (is_a_row) begin
                            w_d     = w_q + 4'd1;
                            state_d = REQ;
                        end else begin
                            state_d = FILL_WAIT;
                        end
                    end
                end
            end
            FILL_WAIT: begin
                if (all_fifos_full) begin
                    sc_d = 1'b1;
                end else if (start_compute) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mat_vec_loader.sv
// Scoreboard bench: memory and FIFO-full models, reference event stream per load, decoupled monitor.
module tb_mat_vec_loader;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, mem_read, mem_readdatavalid, mem_waitrequest;
    logic [31:0] base_addr, mem_address;
    logic [63:0] mem_readdata;
    logic [7:0]  fifo_a_data, fifo_b_data, fifo_a_wren, fifo_a_full;
    logic        fifo_b_wren, fifo_b_full, all_fifos_full, clr_accum, start_compute;

    mat_vec_loader #(.ADDR_W(32), .N(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_addr         (base_addr),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest),
        .fifo_a_data       (fifo_a_data),
        .fifo_a_wren       (fifo_a_wren),
        .fifo_a_full       (fifo_a_full),
        .fifo_b_data       (fifo_b_data),
        .fifo_b_wren       (fifo_b_wren),
        .fifo_b_full       (fifo_b_full),
        .all_fifos_full    (all_fifos_full),
        .clr_accum         (clr_accum),
        .start_compute     (start_compute)
    );

    always #5 clk = ~clk;

    localparam int unsigned EV_CLR = 0, EV_ADDR = 1, EV_AWR = 2, EV_BWR = 3, EV_SC = 4;
    typedef struct {
        int unsigned kind;
        logic [31:0] v1;
        logic [7:0]  v2;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0, failures = 0;
    logic [7:0]  A [8][8];
    logic [7:0]  B [8];
    logic [31:0] cur_base = '0;
    int unsigned lat = 0, wait_word = 99, wait_n = 0, writes = 0;
    bit          stray = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int unsigned kind, input logic [31:0] v1, input logic [7:0] v2,
                             input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected event actual=%h/%h required=none t=%0t", name, v1, v2, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.v1 !== v1 || e.v2 !== v2) begin
                failures++;
                $display("FAIL %s actual=kind%0d %h/%h required=kind%0d %h/%h t=%0t",
                         name, kind, v1, v2, e.kind, e.v1, e.v2, $time);
            end
        end
    endtask

    // Reference: one load is a clear, then nine reads each followed by eight byte writes, then compute.
    task automatic push_load(input logic [31:0] b);
        exp_q.push_back('{EV_CLR, 32'h0, 8'h0});
        for (int w = 0; w < 9; w++) begin
            exp_q.push_back('{EV_ADDR, b + 32'(8 * w), 8'h0});
            for (int k = 0; k < 8; k++) begin
                if (w < 8) exp_q.push_back('{EV_AWR, 32'(1 << w), A[w][k]});
                else       exp_q.push_back('{EV_BWR, 32'h1, B[k]});
            end
        end
        exp_q.push_back('{EV_SC, 32'h0, 8'h0});
    endtask

    function automatic int unsigned word_of(input logic [31:0] addr);
        return int'((addr - cur_base) >> 3);
    endfunction

    function automatic logic [63:0] word_data(input int unsigned w);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = (w < 8) ? A[w][k] : B[k];
        return d;
    endfunction

    // Memory slave: one request at a time, optional waitrequest on one word, fixed extra latency.
    bit          pend_valid = 0, req_active = 0;
    int unsigned pend_cnt = 0, wait_left = 0;
    logic [63:0] pend_data;
    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b0;
        if (rst) begin
            pend_valid = 0;
            req_active = 0;
        end else begin
            if (stray) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
                stray             = 0;
            end else if (pend_valid) begin
                if (pend_cnt == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata      = pend_data;
                    pend_valid        = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (mem_read) begin
                if (!req_active) begin
                    req_active = 1;
                    wait_left  = (word_of(mem_address) == wait_word) ? wait_n : 0;
                end
                if (wait_left > 0) begin
                    mem_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    req_active = 0;
                    pend_valid = 1;
                    pend_cnt   = lat;
                    pend_data  = word_data(word_of(mem_address));
                end
            end
        end
    end

    // Monitor: samples just before each active edge and pops the scoreboard on every DUT event.
    logic [7:0]  prev_a_full = '0;
    logic        prev_b_full = 0, prev_all_full = 0, prev_sc = 0, prev_read = 0;
    logic [31:0] prev_addr = '0;
    int unsigned rd_cycles = 0;
    always @(negedge clk) begin
        #4;
        if (rst) begin
            prev_a_full = '0; prev_b_full = 0; prev_all_full = 0;
            prev_sc = 0; prev_read = 0; rd_cycles = 0;
        end else begin
            if (clr_accum) expect_ev(EV_CLR, 32'h0, 8'h0, "clr_accum");
            if (fifo_a_wren != '0) begin
                check("a_wren_vs_read", {31'b0, mem_read}, 32'h0);
                check("a_wren_vs_full", {24'b0, fifo_a_wren & prev_a_full}, 32'h0);
                expect_ev(EV_AWR, {24'b0, fifo_a_wren}, fifo_a_data, "fifo_a_write");
                writes++;
            end
            if (fifo_b_wren) begin
                check("b_wren_vs_read", {31'b0, mem_read}, 32'h0);
                check("b_wren_vs_full", {31'b0, prev_b_full}, 32'h0);
                expect_ev(EV_BWR, 32'h1, fifo_b_data, "fifo_b_write");
                writes++;
            end
            if (mem_read) begin
                rd_cycles++;
                if (prev_read) check("addr_stable", mem_address, prev_addr);
                if (!mem_waitrequest) begin
                    expect_ev(EV_ADDR, mem_address, 8'h0, "mem_address");
                    check("req_hold_cycles", rd_cycles,
                          (word_of(mem_address) == wait_word) ? wait_n + 1 : 1);
                    rd_cycles = 0;
                end
            end
            if (start_compute && !prev_sc) begin
                check("sc_after_full", {31'b0, prev_all_full}, 32'h1);
                expect_ev(EV_SC, 32'h0, 8'h0, "start_compute");
            end
            if (prev_sc && !prev_all_full)
                check("sc_release", {30'b0, start_compute, done}, 32'h1);
            prev_a_full   = fifo_a_full;
            prev_b_full   = fifo_b_full;
            prev_all_full = all_fifos_full;
            prev_sc       = start_compute;
            prev_read     = mem_read && mem_waitrequest;
            prev_addr     = mem_address;
        end
    end

    task automatic fill(input bit directed);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) A[i][k] = directed ? 8'(16 * i + k) : 8'($urandom);
            B[i] = directed ? 8'(i + 1) : 8'($urandom);
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        base_addr = b;
        cur_base  = b;
        writes    = 0;
        push_load(b);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = $urandom;
        check("busy_after_start", {30'b0, busy, done}, 32'h2);
    endtask

    task automatic finish_load();
        for (int i = 0; i < 3000 && writes < 72; i++) @(negedge clk);
        check("total_writes", writes, 72);
        repeat (2) @(negedge clk);
        all_fifos_full = 1'b1;
        for (int i = 0; i < 20 && !start_compute; i++) @(negedge clk);
        check("start_compute_seen", {31'b0, start_compute}, 32'h1);
        repeat (2) @(negedge clk);
        all_fifos_full = 1'b0;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check("done_busy_end", {29'b0, done, busy, start_compute}, 32'h4);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'b0, busy, done, mem_read, fifo_b_wren, clr_accum, start_compute, 2'b0}, 32'h0);
        check({tag, "_addr"}, mem_address, 32'h0);
        check({tag, "_a"}, {16'b0, fifo_a_wren, fifo_a_data}, 32'h0);
        check({tag, "_bdata"}, {24'b0, fifo_b_data}, 32'h0);
    endtask

    int unsigned snap;
    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0;
        fifo_a_full = '0; fifo_b_full = 1'b0; all_fifos_full = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed contents, zero extra latency.
        fill(1); lat = 0;
        do_start(32'h0000_1000);
        finish_load();

        // Waitrequest on word 4 plus latency 5.
        fill(0); lat = 5; wait_word = 4; wait_n = 3;
        do_start(32'h0000_1000);
        finish_load();
        wait_word = 99; wait_n = 0;

        // Row 2 FIFO full for four cycles in mid-row.
        fill(0); lat = 2;
        do_start(32'h0000_4000 + ($urandom & 32'h0FF8));
        for (int i = 0; i < 3000 && writes < 19; i++) @(negedge clk);
        fifo_a_full[2] = 1'b1;
        repeat (4) @(negedge clk);
        fifo_a_full[2] = 1'b0;
        finish_load();

        // Reset during row 5, then a stray readdatavalid.
        fill(0); lat = 1;
        do_start(32'h0000_2000);
        for (int i = 0; i < 3000 && writes < 42; i++) @(negedge clk);
        check("reached_row5", {31'b0, writes >= 42}, 32'h1);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        snap = writes;
        @(posedge clk);
        stray = 1;
        repeat (6) @(negedge clk);
        check("stray_no_write", writes, snap);
        check("stray_idle", {30'b0, busy, mem_read}, 32'h0);
        do_start(32'h0000_2000);
        finish_load();

        // Ignored start during REQ of word 3, then restart from DONE.
        fill(0); lat = $urandom_range(0, 4);
        do_start(32'h0000_8000);
        for (int i = 0; i < 3000 && !(mem_read && mem_address == cur_base + 32'h18); i++) @(negedge clk);
        check("req_word3_seen", mem_address, cur_base + 32'h18);
        start = 1'b1; base_addr = 32'h0BAD_0000;
        @(negedge clk);
        start = 1'b0;
        finish_load();
        fill(0);
        do_start(32'h0000_9000);
        finish_load();

        // Address wrap-around.
        fill(0); lat = 1;
        do_start(32'hFFFF_FFE0);
        finish_load();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mat_vec_loader.md
Name: mat_vec_loader

Overview:
Upstream loader for the 8x8 matrix-vector MAC array. On `start` it fetches the 8 rows of A and the vector B from memory over a 64-bit pipelined read port. It unpacks each word into bytes and writes them into the per-row A FIFOs and the B FIFO. Once the MAC array reports all FIFOs full, it issues the accumulator-clear and start-compute pulses that the MAC array consumes.

Parameters:
ADDR_W, 32, memory byte-address width
N, 8, rows of A = bytes per memory word = FIFO depth; the datapath is sized for N=8 only

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle load request; ignored unless in IDLE or DONE
base_addr  input  ADDR_W  byte address of A row 0; sampled on accepted start
busy  output  1  high from accepted start until DONE
done  output  1  high in DONE until next accepted start or reset
mem_address  output  ADDR_W  read address
mem_read  output  1  read request
mem_readdata  input  64  read data; byte k = bits [8k+7:8k]
mem_readdatavalid  input  1  readdata valid
mem_waitrequest  input  1  slave stall; request held while high
fifo_a_data  output  8  byte broadcast to all 8 A FIFO data inputs
fifo_a_wren  output  N  one-hot A FIFO write enable
fifo_a_full  input  N  A FIFO full flags
fifo_b_data  output  8  B FIFO write data
fifo_b_wren  output  1  B FIFO write enable
fifo_b_full  input  1  B FIFO full flag
all_fifos_full  input  1  from MAC array
clr_accum  output  1  one-cycle pulse clearing the MAC accumulators
start_compute  output  1  held high until the MAC array leaves IDLE (see FILL_WAIT)

Behaviour:
- Reset: all outputs 0, state IDLE, word counter w=0, byte counter b=0. Reset mid-operation aborts immediately. Any mem_readdatavalid arriving after reset is ignored.
- Memory map: word w (0..8) is at base_addr + 8*w. Words 0..7 hold A row w. Word 8 holds B. Byte k of a word is element k.
- All outputs are registered.
- States:
  - IDLE / DONE: an accepted start latches base_addr, sets w=0, drives clr_accum=1 for 1 cycle, then moves to REQ.
  - REQ: mem_read=1, mem_address=base+8*w. Hold both while mem_waitrequest=1. On the cycle with waitrequest=0, the request is accepted: drop mem_read and go to RESP. Only one read is outstanding at a time.
  - RESP: wait for mem_readdatavalid. Capture mem_readdata into a 64-bit word register, set b=0, go to UNPK. readdatavalid seen in any other state is ignored.
  - UNPK: write byte b to the target FIFO. The target is A FIFO w for w<8, else the B FIFO.
    - If the target's full flag is 0: drive the write enable for one cycle with data = byte b, then increment b.
    - If the target is full: write enable low and b held (stall; this is not an error).
    - After b=7 is written: if w<8, increment w and go to REQ; else go to FILL_WAIT.
  - FILL_WAIT: wait until all_fifos_full=1, then drive start_compute=1. Hold it high while start_compute && all_fifos_full (the MAC array consumes it and begins draining FIFOs). When all_fifos_full drops, deassert and go to DONE.
- Write enables are never asserted in the same cycle as mem_read.
- Throughput: at least 9 x (2 + memory latency + 8) cycles per load.
- start while busy is ignored; start in DONE restarts a full load.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package `mat_vec_pkg`:
  - state enum (IDLE, REQ, RESP, UNPK, FILL_WAIT, DONE)
  - N_ROWS=8, WORDS_PER_LOAD=9, BYTES_PER_WORD=8
- One natural sub-module, `word_unpacker`: 64-bit capture register plus byte counter, with a stall input and a last-byte flag.

Test Plan:
- Zero-latency memory, no waitrequest, base=0x1000, A[i][k]=16i+k, B[k]=k+1. Required response:
  - addresses 0x1000..0x1040 in order
  - fifo_a_wren = 8'h01 x8 with bytes 0x00..0x07, then 8'h02 x8 with bytes 0x10..0x17, and so on through row 7
  - fifo_b_wren x8 with bytes 1..8
  - clr_accum pulses once, first
  - start_compute rises only after all_fifos_full=1; done=1 at the end
- waitrequest held 3 cycles on word 4 plus 5-cycle read latency: mem_address stays 0x1020 for 4 cycles with mem_read high. Data and ordering are identical to scenario 1.
- fifo_a_full[2] forced high for 4 cycles mid-row-2: wren stalls and byte b is held. The resumed sequence is contiguous with no byte lost or duplicated.
- rst asserted during UNPK of row 5, then a stray readdatavalid arrives: all outputs 0 and state IDLE. No FIFO write occurs. A new start reloads from word 0.
- start pulsed again during REQ of word 3: no effect, addresses unchanged. start pulsed in DONE: a full reload begins with a clr_accum pulse.
- base_addr=0xFFFF_FFE0: addresses wrap through 0x0000_0000 correctly.
